// File: rtl/lz_norm_seq.sv
// Multi-cycle leading-zero normalizer for wide mantissas.
// One 32-bit LZ counter is reused across chunks, MSB chunk first.
module lz_norm_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_lz,
  output logic             out_zero
);

  localparam int NCH = WIDTH / 32;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic [CNT_W-1:0] olz_q, olz_d;
  logic             ozero_q, ozero_d;

  logic [WIDTH-1:0] shifted;
  logic [31:0]      chunk;
  logic             chunk_nz;

  // Count is meaningless for an all-zero input; callers gate on chunk_nz.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 5'(31 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  assign shifted  = data_q << {k_q, 5'b0};
  assign chunk    = shifted[WIDTH-1 -: 32];
  assign chunk_nz = |chunk;

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = odata_q;
  assign out_lz    = olz_q;
  assign out_zero  = ozero_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    acc_d   = acc_q;
    odata_d = odata_q;
    olz_d   = olz_q;
    ozero_d = ozero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          k_d     = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_nz) begin
          acc_d   = acc_q + CNT_W'(lzc32(chunk));
          state_d = SHIFT;
        end else begin
          acc_d = acc_q + CNT_W'(32);
          k_d   = k_q + 1'b1;
          if (k_q == KW'(NCH - 1)) begin
            odata_d = '0;
            olz_d   = acc_q + CNT_W'(32);
            ozero_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        odata_d = data_q << acc_q;
        olz_d   = acc_q;
        ozero_d = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      odata_q <= '0;
      olz_q   <= '0;
      ozero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      odata_q <= odata_d;
      olz_q   <= olz_d;
      ozero_q <= ozero_d;
    end
  end

endmodule
